// File: rtl/change_dispenser_if.sv
// Hopper handshake: the dispenser requests one coin of a selected denomination
// and holds the request until the hopper acknowledges the ejection.
interface change_dispenser_if;
    logic       COIN_REQ;
    logic [1:0] COIN_SEL;
    logic       COIN_ACK;

    modport master (
        output COIN_REQ,
        output COIN_SEL,
        input  COIN_ACK
    );

    modport slave (
        input  COIN_REQ,
        input  COIN_SEL,
        output COIN_ACK
    );
endinterface

// File: rtl/change_dispenser.sv
// Change-return controller: snapshots the balance on START, pays it out greedily
// in 1000/500/100/50 coins through the hopper handshake and pulses one MINUS_*
// per dispensed coin so the money register drains in step.
module change_dispenser #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [15:0] BALANCE,
    change_dispenser_if.master hopper,
    output logic        MINUS_1000,
    output logic        MINUS_500,
    output logic        MINUS_100,
    output logic        MINUS_50,
    output logic        BUSY,
    output logic        DONE,
    output logic        RESIDUE,
    output logic        FAULT,
    output logic [7:0]  CNT_1000,
    output logic [7:0]  CNT_500,
    output logic [7:0]  CNT_100,
    output logic [7:0]  CNT_50
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_DEC,
        S_FINISH,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] remain;
    logic [1:0]  sel;
    logic [15:0] tcnt;
    logic        residue_q;
    logic [7:0]  coin_cnt [4];
    logic [15:0] coin_value;
    logic [16:0] tcnt_inc;
    logic        timeout_hit;

    // The timeout fires on the cycle that would make the wait count reach TIMEOUT.
    assign tcnt_inc    = {1'b0, tcnt} + 17'd1;
    assign timeout_hit = (tcnt_inc == 17'(TIMEOUT));

    // Face value of the currently selected denomination.
    always_comb begin
        coin_value = 16'd50;
        case (sel)
            2'd0:    coin_value = 16'd1000;
            2'd1:    coin_value = 16'd500;
            2'd2:    coin_value = 16'd100;
            default: coin_value = 16'd50;
        endcase
    end

    // State register; reset abandons any handshake in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; START only matters in IDLE and FAULT, COIN_ACK only in REQ.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (START) state_next = S_SELECT;
            S_SELECT: state_next = (remain >= 16'd50) ? S_REQ : S_FINISH;
            S_REQ: begin
                if (hopper.COIN_ACK) begin
                    state_next = S_DEC;
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_DEC:    state_next = S_SELECT;
            S_FINISH: state_next = S_IDLE;
            S_FAULT:  if (START) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Payout datapath: remaining amount, chosen coin, wait counter, residue flag and coin tallies.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            remain    <= '0;
            sel       <= '0;
            tcnt      <= '0;
            residue_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                coin_cnt[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        remain    <= BALANCE;
                        residue_q <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            coin_cnt[i] <= '0;
                        end
                    end
                end
                S_SELECT: begin
                    tcnt <= '0;
                    if (remain >= 16'd1000) begin
                        sel <= 2'd0;
                    end else if (remain >= 16'd500) begin
                        sel <= 2'd1;
                    end else if (remain >= 16'd100) begin
                        sel <= 2'd2;
                    end else if (remain >= 16'd50) begin
                        sel <= 2'd3;
                    end else if (remain != 16'd0) begin
                        residue_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!hopper.COIN_ACK) begin
                        tcnt <= tcnt_inc[15:0];
                    end
                end
                S_DEC: begin
                    remain        <= remain - coin_value;
                    coin_cnt[sel] <= coin_cnt[sel] + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from the state and registers.
    always_comb begin
        hopper.COIN_REQ = 1'b0;
        hopper.COIN_SEL = 2'd0;
        MINUS_1000      = 1'b0;
        MINUS_500       = 1'b0;
        MINUS_100       = 1'b0;
        MINUS_50        = 1'b0;
        BUSY            = 1'b0;
        DONE            = 1'b0;
        FAULT           = 1'b0;
        case (state)
            S_SELECT: BUSY = 1'b1;
            S_REQ: begin
                BUSY            = 1'b1;
                hopper.COIN_REQ = 1'b1;
                hopper.COIN_SEL = sel;
            end
            S_DEC: begin
                BUSY       = 1'b1;
                MINUS_1000 = (sel == 2'd0);
                MINUS_500  = (sel == 2'd1);
                MINUS_100  = (sel == 2'd2);
                MINUS_50   = (sel == 2'd3);
            end
            S_FINISH: DONE  = 1'b1;
            S_FAULT:  FAULT = 1'b1;
            default: begin
            end
        endcase
    end

    assign RESIDUE  = residue_q;
    assign CNT_1000 = coin_cnt[0];
    assign CNT_500  = coin_cnt[1];
    assign CNT_100  = coin_cnt[2];
    assign CNT_50   = coin_cnt[3];

endmodule
